// File: rtl/fma16_pkg.sv
// Shared types for the fma16 arbiter: opcode encoding, datapath controls and opcode decoder.
package fma16_pkg;

    typedef enum logic [2:0] {
        OpFadd   = 3'b000,
        OpFsub   = 3'b001,
        OpFmul   = 3'b010,
        OpFmadd  = 3'b011,
        OpFmsub  = 3'b100,
        OpFnmadd = 3'b101,
        OpFnmsub = 3'b110,
        OpRsvd   = 3'b111
    } fma_op_t;

    typedef struct packed {
        logic mul;
        logic add;
        logic negr;
        logic negz;
    } fma_ctrl_t;

    typedef struct packed {
        fma_ctrl_t ctrl;
        logic      err;
    } fma_dec_t;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    function automatic fma_dec_t decode_op(input fma_op_t op);
        fma_dec_t d;
        d = '0;
        unique case (op)
            OpFadd:   d.ctrl = '{mul: 1'b0, add: 1'b1, negr: 1'b0, negz: 1'b0};
            OpFsub:   d.ctrl = '{mul: 1'b0, add: 1'b1, negr: 1'b0, negz: 1'b1};
            OpFmul:   d.ctrl = '{mul: 1'b1, add: 1'b0, negr: 1'b0, negz: 1'b0};
            OpFmadd:  d.ctrl = '{mul: 1'b1, add: 1'b1, negr: 1'b0, negz: 1'b0};
            OpFmsub:  d.ctrl = '{mul: 1'b1, add: 1'b1, negr: 1'b0, negz: 1'b1};
            OpFnmadd: d.ctrl = '{mul: 1'b1, add: 1'b1, negr: 1'b1, negz: 1'b0};
            OpFnmsub: d.ctrl = '{mul: 1'b1, add: 1'b1, negr: 1'b1, negz: 1'b1};
            OpRsvd:   d.err  = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/fma16.sv
// Combinational fp16 fused multiply-add: result = (negr ? -1 : 1) * (x*y' + (negz ? -z' : z')),
// with y' = 1.0 when mul=0 and z' = 0 when add=0. Single rounding in the selected mode.
module fma16 (
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic [15:0] i_z,
    input  logic        i_mul,
    input  logic        i_add,
    input  logic        i_negr,
    input  logic        i_negz,
    input  logic [1:0]  i_rm,
    output logic [15:0] o_result
);
    // Exact fixed-point sum, LSB weight 2^-48; wide enough for every finite product and addend.
    localparam int unsigned AW = 82;

    logic [15:0]   w_y, w_z;
    logic [10:0]   w_xm, w_ym, w_zm;
    logic [4:0]    w_xe, w_ye, w_ze;
    logic          w_x_nan, w_y_nan, w_z_nan, w_x_inf, w_y_inf, w_z_inf, w_x_zero, w_y_zero;
    logic          w_ps, w_zs, w_neg, w_fs, w_p_inf, w_nan;
    logic [21:0]   w_prod;
    logic [6:0]    w_pexp, w_zsh, w_lead, w_sh, w_exp;
    logic [AW-1:0] w_pmag, w_zmag, w_sum, w_mag, w_lowmask;
    logic [9:0]    w_kept;
    logic          w_guard, w_sticky, w_inc, w_ovf;
    logic [16:0]   w_rnd;
    logic [14:0]   w_ovf_mag;

    assign w_y = i_mul ? i_y : 16'h3C00;
    assign w_z = i_add ? i_z : 16'h0000;

    assign w_xe = (i_x[14:10] == 5'd0) ? 5'd1 : i_x[14:10];
    assign w_ye = (w_y[14:10] == 5'd0) ? 5'd1 : w_y[14:10];
    assign w_ze = (w_z[14:10] == 5'd0) ? 5'd1 : w_z[14:10];
    assign w_xm = {|i_x[14:10], i_x[9:0]};
    assign w_ym = {|w_y[14:10], w_y[9:0]};
    assign w_zm = {|w_z[14:10], w_z[9:0]};

    assign w_x_nan  = (&i_x[14:10]) & (|i_x[9:0]);
    assign w_y_nan  = (&w_y[14:10]) & (|w_y[9:0]);
    assign w_z_nan  = (&w_z[14:10]) & (|w_z[9:0]);
    assign w_x_inf  = (&i_x[14:10]) & ~(|i_x[9:0]);
    assign w_y_inf  = (&w_y[14:10]) & ~(|w_y[9:0]);
    assign w_z_inf  = (&w_z[14:10]) & ~(|w_z[9:0]);
    assign w_x_zero = ~(|i_x[14:0]);
    assign w_y_zero = ~(|w_y[14:0]);

    assign w_ps    = i_x[15] ^ w_y[15];
    assign w_zs    = w_z[15] ^ i_negz;
    assign w_p_inf = w_x_inf | w_y_inf;
    assign w_nan   = w_x_nan | w_y_nan | w_z_nan | (w_x_inf & w_y_zero) | (w_y_inf & w_x_zero)
                   | (w_p_inf & w_z_inf & (w_ps != w_zs));

    assign w_prod = {11'b0, w_xm} * {11'b0, w_ym};
    assign w_pexp = {2'b0, w_xe} + {2'b0, w_ye} - 7'd2;
    assign w_zsh  = {2'b0, w_ze} + 7'd23;
    assign w_pmag = {60'b0, w_prod} << w_pexp;
    assign w_zmag = {71'b0, w_zm} << w_zsh;
    assign w_sum  = (w_ps ? -w_pmag : w_pmag) + (w_zs ? -w_zmag : w_zmag);
    assign w_neg  = w_sum[AW-1];
    assign w_mag  = w_neg ? -w_sum : w_sum;

    always_comb begin
        w_lead = '0;
        for (int i = 0; i < AW; i++) begin
            if (w_mag[i]) w_lead = 7'(i);
        end
    end

    // An exact zero takes the operands' common sign, otherwise +0 except when rounding down.
    always_comb begin
        w_fs = w_neg;
        if (w_mag == '0) w_fs = (w_ps == w_zs) ? w_ps : (i_rm == 2'b11);
        w_fs = w_fs ^ i_negr;
    end

    // Bit 34 is the hidden-bit position of the smallest normal; below it the LSB stays at 2^-24.
    assign w_sh        = ((w_lead > 7'd34) ? w_lead : 7'd34) - 7'd10;
    assign w_exp       = (w_lead >= 7'd34) ? (w_lead - 7'd33) : 7'd0;
    assign w_kept      = 10'(w_mag >> w_sh);
    assign w_guard     = w_mag[w_sh - 7'd1];
    assign w_lowmask   = ({{(AW-1){1'b0}}, 1'b1} << (w_sh - 7'd1)) - {{(AW-1){1'b0}}, 1'b1};
    assign w_sticky    = |(w_mag & w_lowmask);

    always_comb begin
        w_inc = 1'b0;
        case (i_rm)
            2'b01:   w_inc = w_guard & (w_sticky | w_kept[0]);
            2'b10:   w_inc = ~w_fs & (w_guard | w_sticky);
            2'b11:   w_inc = w_fs & (w_guard | w_sticky);
            default: w_inc = 1'b0;
        endcase
    end

    assign w_rnd = {w_exp, w_kept} + {16'b0, w_inc};
    assign w_ovf = (w_rnd >= 17'h07C00);

    always_comb begin
        w_ovf_mag = 15'h7C00;
        case (i_rm)
            2'b00:   w_ovf_mag = 15'h7BFF;
            2'b10:   w_ovf_mag = w_fs ? 15'h7BFF : 15'h7C00;
            2'b11:   w_ovf_mag = w_fs ? 15'h7C00 : 15'h7BFF;
            default: w_ovf_mag = 15'h7C00;
        endcase
    end

    always_comb begin
        if (w_nan)        o_result = 16'h7E00;
        else if (w_p_inf) o_result = {w_ps ^ i_negr, 15'h7C00};
        else if (w_z_inf) o_result = {w_zs ^ i_negr, 15'h7C00};
        else if (w_ovf)   o_result = {w_fs, w_ovf_mag};
        else              o_result = {w_fs, w_rnd[14:0]};
    end

endmodule

// File: rtl/fma16_arbiter_rr.sv
// Round-robin arbiter: grants the first requester after the last winner; owns the priority pointer.
module rr_arbiter #(
    parameter  int unsigned NREQ = 2,
    localparam int unsigned IDW  = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_en,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_gnt_idx
);
    logic [IDW-1:0] r_ptr;
    logic           w_found;
    int unsigned    w_idx;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && i_req[w_idx]) begin
                w_found   = 1'b1;
                o_gnt_idx = IDW'(w_idx);
            end
        end
        if (i_en && w_found) o_gnt[o_gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= IDW'(NREQ - 1);
        end else if (i_en && w_found) begin
            r_ptr <= o_gnt_idx;
        end
    end

endmodule

// File: rtl/fma16_arbiter.sv
// Shares one fma16 among NREQ requesters: round-robin grant, issue stage S1, result stage S2.
// Define FMA16_ARB_PERF_EN to add per-requester issue counters and a stall counter.
module fma16_arbiter
    import fma16_pkg::*;
#(
    parameter  int unsigned NREQ = 2,
    parameter  int unsigned TAGW = 4,
    localparam int unsigned IDW  = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*16-1:0]   req_x,
    input  logic [NREQ*16-1:0]   req_y,
    input  logic [NREQ*16-1:0]   req_z,
    input  logic [NREQ*3-1:0]    req_op,
    input  logic [NREQ*2-1:0]    req_rm,
    input  logic [NREQ*TAGW-1:0] req_tag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [TAGW-1:0]      rsp_tag,
    output logic [15:0]          rsp_result,
    output logic                 rsp_err,
    output logic                 busy
`ifdef FMA16_ARB_PERF_EN
    ,
    output logic [NREQ*16-1:0]   perf_issue_cnt,
    output logic [15:0]          perf_stall_cnt
`endif
);
    logic            r_s1_valid, r_s1_err;
    logic [15:0]     r_s1_x, r_s1_y, r_s1_z;
    fma_ctrl_t       r_s1_ctrl;
    logic [1:0]      r_s1_rm;
    logic [IDW-1:0]  r_s1_id;
    logic [TAGW-1:0] r_s1_tag;

    logic            r_s2_valid, r_s2_err;
    logic [15:0]     r_s2_result;
    logic [IDW-1:0]  r_s2_id;
    logic [TAGW-1:0] r_s2_tag;

    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_gnt_idx;
    logic            w_adv2, w_s1_free, w_hs;
    fma_dec_t        w_dec;
    logic [15:0]     w_fma_result;

    assign w_adv2    = r_s1_valid & (~r_s2_valid | rsp_ready);
    assign w_s1_free = ~r_s1_valid | w_adv2;

    // Gating with reset keeps req_ready low while reset is held, even though S1 reads as free.
    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk       (clk),
        .rst       (reset),
        .i_req     (req_valid),
        .i_en      (w_s1_free & ~reset),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign req_ready = w_gnt;
    assign w_hs      = |(req_valid & w_gnt);
    assign w_dec     = decode_op(fma_op_t'(req_op[3*w_gnt_idx +: 3]));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_z     <= '0;
            r_s1_ctrl  <= '0;
            r_s1_rm    <= '0;
            r_s1_id    <= '0;
            r_s1_tag   <= '0;
        end else begin
            if (w_hs) begin
                r_s1_valid <= 1'b1;
                r_s1_err   <= w_dec.err;
                r_s1_x     <= req_x[16*w_gnt_idx +: 16];
                r_s1_y     <= req_y[16*w_gnt_idx +: 16];
                r_s1_z     <= req_z[16*w_gnt_idx +: 16];
                r_s1_ctrl  <= w_dec.ctrl;
                r_s1_rm    <= req_rm[2*w_gnt_idx +: 2];
                r_s1_id    <= w_gnt_idx;
                r_s1_tag   <= req_tag[TAGW*w_gnt_idx +: TAGW];
            end else if (w_adv2) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    fma16 u_fma16 (
        .i_x      (r_s1_x),
        .i_y      (r_s1_y),
        .i_z      (r_s1_z),
        .i_mul    (r_s1_ctrl.mul),
        .i_add    (r_s1_ctrl.add),
        .i_negr   (r_s1_ctrl.negr),
        .i_negz   (r_s1_ctrl.negz),
        .i_rm     (r_s1_rm),
        .o_result (w_fma_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid  <= 1'b0;
            r_s2_err    <= 1'b0;
            r_s2_result <= '0;
            r_s2_id     <= '0;
            r_s2_tag    <= '0;
        end else if (w_adv2) begin
            r_s2_valid  <= 1'b1;
            r_s2_err    <= r_s1_err;
            r_s2_result <= r_s1_err ? FP16_QNAN : w_fma_result;
            r_s2_id     <= r_s1_id;
            r_s2_tag    <= r_s1_tag;
        end else if (rsp_ready) begin
            r_s2_valid  <= 1'b0;
        end
    end

    assign rsp_valid  = r_s2_valid;
    assign rsp_result = r_s2_result;
    assign rsp_id     = r_s2_id;
    assign rsp_tag    = r_s2_tag;
    assign rsp_err    = r_s2_err;
    assign busy       = r_s1_valid | r_s2_valid;

`ifdef FMA16_ARB_PERF_EN
    logic [15:0] r_stall_cnt;

    for (genvar g = 0; g < NREQ; g++) begin : g_perf
        logic [15:0] r_cnt;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (req_valid[g] && w_gnt[g] && r_cnt != 16'hFFFF) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
        assign perf_issue_cnt[16*g +: 16] = r_cnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (r_s2_valid && !rsp_ready && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fma16_arbiter.sv
// Directed self-checking bench for fma16_arbiter (NREQ=2, TAGW=4).
module tb_fma16_arbiter;
    localparam int unsigned NREQ = 2;
    localparam int unsigned TAGW = 4;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*16-1:0] req_x, req_y, req_z;
    logic [NREQ*3-1:0] req_op;
    logic [NREQ*2-1:0] req_rm;
    logic [NREQ*TAGW-1:0] req_tag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [0:0]        rsp_id;
    logic [TAGW-1:0]   rsp_tag;
    logic [15:0]       rsp_result;
    logic              rsp_err;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    fma16_arbiter #(
        .NREQ (NREQ),
        .TAGW (TAGW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_z      (req_z),
        .req_op     (req_op),
        .req_rm     (req_rm),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_tag    (rsp_tag),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] z, input logic [2:0] op, input logic [3:0] tag);
        req_valid[i]        = v;
        req_x[16*i +: 16]   = x;
        req_y[16*i +: 16]   = y;
        req_z[16*i +: 16]   = z;
        req_op[3*i +: 3]    = op;
        req_rm[2*i +: 2]    = 2'b01;
        req_tag[4*i +: 4]   = tag;
    endtask

    // One request from requester i into an empty pipeline; response expected two edges later.
    task automatic single(input string name, input int i, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] z, input logic [2:0] op,
                          input logic [3:0] tag, input logic [15:0] exp_res, input logic exp_err);
        @(posedge clk); #1;
        drive(i, 1'b1, x, y, z, op, tag);
        #1;
        check({name, ".ready"}, req_ready, 32'(1 << i));
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        check({name, ".s1_only"}, {busy, rsp_valid}, 32'b10);
        @(posedge clk); #1;
        check({name, ".valid"}, rsp_valid, 1);
        check({name, ".result"}, rsp_result, exp_res);
        check({name, ".id"}, rsp_id, i);
        check({name, ".tag"}, rsp_tag, tag);
        check({name, ".err"}, rsp_err, exp_err);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 2'b11;
        req_x     = '0;
        req_y     = '0;
        req_z     = '0;
        req_op    = '0;
        req_rm    = '0;
        req_tag   = '0;
        rsp_ready = 1'b1;
        #12;
        check("reset.ready", req_ready, 0);
        check("reset.valid", rsp_valid, 0);
        check("reset.busy", busy, 0);
        check("reset.result", rsp_result, 0);
        check("reset.id_tag_err", {rsp_id, rsp_tag, rsp_err}, 0);
        req_valid = 2'b00;
        #5 reset = 1'b0;

        single("fmul", 0, 16'h4000, 16'h4200, 16'h0000, 3'b010, 4'd5, 16'h4600, 1'b0);
        single("fmadd", 0, 16'h4000, 16'h4200, 16'h3C00, 3'b011, 4'd6, 16'h4700, 1'b0);
        single("fnmsub", 1, 16'h4000, 16'h4200, 16'h3C00, 3'b110, 4'd7, 16'hC500, 1'b0);
        single("rsvd", 0, 16'h4000, 16'h4200, 16'h3C00, 3'b111, 4'd3, 16'h7E00, 1'b1);
        single("fadd", 1, 16'h3C00, 16'h5555, 16'h4000, 3'b000, 4'd8, 16'h4200, 1'b0);

        // Round robin: last winner was 1, so 0 goes first.
        @(posedge clk); #1;
        drive(0, 1'b1, 16'h3C00, 16'h0000, 16'h3C00, 3'b000, 4'hA);
        drive(1, 1'b1, 16'h4000, 16'h4200, 16'h0000, 3'b010, 4'hB);
        for (int c = 0; c < 6; c++) begin
            if (c == 4) req_valid = 2'b00;
            #1;
            if (c < 4) check("rr.ready", req_ready, (c % 2 == 0) ? 1 : 2);
            if (c >= 2) begin
                check("rr.valid", rsp_valid, 1);
                check("rr.id", rsp_id, c % 2);
                check("rr.result", rsp_result, (c % 2 == 0) ? 16'h4000 : 16'h4600);
                check("rr.tag", rsp_tag, (c % 2 == 0) ? 4'hA : 4'hB);
            end
            @(posedge clk); #1;
        end
        check("rr.drained", {busy, rsp_valid}, 0);

        // Backpressure: two ops fill S1 and S2, then grants stop and S2 holds.
        rsp_ready = 1'b0;
        drive(0, 1'b1, 16'h3C00, 16'h0000, 16'h3C00, 3'b000, 4'd1);
        drive(1, 1'b1, 16'h4000, 16'h4200, 16'h0000, 3'b010, 4'd2);
        #1 check("bp.ready0", req_ready, 1);
        @(posedge clk); #1;
        check("bp.ready1", req_ready, 2);
        @(posedge clk); #1;
        check("bp.ready2", req_ready, 0);
        check("bp.hold", {rsp_valid, busy, rsp_id, rsp_result, rsp_tag}, {2'b11, 1'b0, 16'h4000, 4'd1});
        @(posedge clk); #1;
        check("bp.ready3", req_ready, 0);
        check("bp.stable", {rsp_valid, rsp_id, rsp_result, rsp_tag, rsp_err},
              {1'b1, 1'b0, 16'h4000, 4'd1, 1'b0});
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        check("bp.second", {rsp_valid, rsp_id, rsp_result, rsp_tag}, {1'b1, 1'b1, 16'h4600, 4'd2});
        @(posedge clk); #1;
        check("bp.drained", {busy, rsp_valid}, 0);

        // Fill with 1 then 0 so the live pointer would favour 1; reset must restore 0 first.
        rsp_ready = 1'b0;
        drive(1, 1'b1, 16'h4000, 16'h4200, 16'h0000, 3'b010, 4'd4);
        #1 check("rst.fill1", req_ready, 2);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        drive(0, 1'b1, 16'h3C00, 16'h0000, 16'h3C00, 3'b000, 4'd9);
        #1 check("rst.fill0", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 2'b11;
        #1 check("rst.full", {req_ready, busy}, {2'b00, 1'b1});
        #1 reset = 1'b1;
        #1 check("rst.async", {rsp_valid, busy, req_ready}, 0);
        #3 reset = 1'b0;
        #1 check("rst.first_grant", req_ready, 1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 2'b00;
        check("rst.s1", {busy, rsp_valid}, 32'b10);
        @(posedge clk); #1;
        check("rst.rsp", {rsp_valid, rsp_id, rsp_result, rsp_tag}, {1'b1, 1'b0, 16'h4000, 4'd9});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
